// File: rtl/ctrl_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pipe_pkg
// Purpose  : Control-word layout, bubble constant and stage-0 action decode
// Revision : 1.0
// ============================================================================
package ctrl_pipe_pkg;

  localparam int c_CW_DEF = 16;

  // Control-word field offsets (default 16-bit layout)
  localparam int c_RF_E_BIT      = 0;
  localparam int c_MEM_E_BIT     = 1;
  localparam int c_MEM_SIZE_LSB  = 2;
  localparam int c_MEM_SIZE_W    = 2;
  localparam int c_BL_BIT        = 4;
  localparam int c_B_BIT         = 5;
  localparam int c_STORE_CC_BIT  = 6;
  localparam int c_MEM_WRITE_BIT = 7;
  localparam int c_LOAD_BIT      = 8;
  localparam int c_AM_LSB        = 9;
  localparam int c_AM_W          = 2;
  localparam int c_ALU_OP_LSB    = 11;
  localparam int c_ALU_OP_W      = 4;

  typedef struct packed {
    logic       spare;
    logic [3:0] alu_op;
    logic [1:0] am;
    logic       load;
    logic       mem_write;
    logic       store_cc;
    logic       b;
    logic       bl;
    logic [1:0] mem_size;
    logic       mem_e;
    logic       rf_e;
  } ctrl_word_t;

  localparam logic [c_CW_DEF-1:0] c_BUBBLE  = '0;
  localparam logic [15:0]         c_CNT_SAT = 16'hFFFF;

  typedef enum logic [1:0] {
    S0_LOAD   = 2'd0,
    S0_HOLD   = 2'd1,
    S0_BUBBLE = 2'd2
  } s0_act_e;

  // Stage-0 priority: flush beats stall beats nop_sel beats a normal load.
  function automatic s0_act_e s0_action(input logic flush, input logic stall,
                                        input logic nop_sel);
    s0_act_e act;
    if (flush)        act = S0_BUBBLE;
    else if (stall)   act = S0_HOLD;
    else if (nop_sel) act = S0_BUBBLE;
    else              act = S0_LOAD;
    return act;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_stage_reg
// Purpose  : One pipeline slot: control word plus valid, with load/hold/bubble
// Revision : 1.0
// ============================================================================
module ctrl_stage_reg
  import ctrl_pipe_pkg::*;
#(
  parameter int CW = c_CW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_en,
  input  logic          bubble,
  input  logic [CW-1:0] d_ctrl,
  input  logic          d_valid,
  output logic [CW-1:0] q_ctrl,
  output logic          q_valid
);

  logic [CW-1:0] r_ctrl;
  logic          r_valid;

  // An invalid word is stored as all-zero so downstream strobes can never fire.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ctrl  <= CW'(c_BUBBLE);
      r_valid <= 1'b0;
    end else if (bubble) begin
      r_ctrl  <= CW'(c_BUBBLE);
      r_valid <= 1'b0;
    end else if (load_en) begin
      r_ctrl  <= d_valid ? d_ctrl : CW'(c_BUBBLE);
      r_valid <= d_valid;
    end
  end

  assign q_ctrl  = r_ctrl;
  assign q_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pipe
// Purpose  : Post-decode control-word pipeline with stall/flush/bubble insert
// Revision : 1.0
// ============================================================================
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int CW       = c_CW_DEF,
  parameter int STAGES   = 3,
  parameter int RF_E_BIT = c_RF_E_BIT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CW-1:0]        id_ctrl,
  input  logic                 id_valid,
  input  logic                 nop_sel,
  input  logic                 stall,
  input  logic                 flush,
  output logic [STAGES*CW-1:0] stage_ctrl,
  output logic [STAGES-1:0]    stage_valid,
  output logic                 wb_rf_e,
  output logic [15:0]          bubble_cnt
);

  s0_act_e                  w_s0_act;
  logic                     w_s0_load;
  logic                     w_s0_bubble;
  logic                     w_s1_bubble;
  logic                     w_cnt_inc;
  logic [STAGES-1:0][CW-1:0] w_q_ctrl;
  logic [STAGES-1:0]        w_q_valid;
  logic [15:0]              r_bubble_cnt;

  assign w_s0_act    = s0_action(flush, stall, nop_sel);
  assign w_s0_load   = (w_s0_act == S0_LOAD);
  assign w_s0_bubble = (w_s0_act == S0_BUBBLE);
  // A stall starves stage 1 while stage 0 holds; flush overrides the stall.
  assign w_s1_bubble = stall & ~flush;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      ctrl_stage_reg #(.CW(CW)) u_reg (
        .clk     (clk),
        .reset   (reset),
        .load_en (w_s0_load),
        .bubble  (w_s0_bubble),
        .d_ctrl  (id_ctrl),
        .d_valid (id_valid),
        .q_ctrl  (w_q_ctrl[k]),
        .q_valid (w_q_valid[k])
      );
    end else if (k == 1) begin : g_second
      ctrl_stage_reg #(.CW(CW)) u_reg (
        .clk     (clk),
        .reset   (reset),
        .load_en (1'b1),
        .bubble  (w_s1_bubble),
        .d_ctrl  (w_q_ctrl[k-1]),
        .d_valid (w_q_valid[k-1]),
        .q_ctrl  (w_q_ctrl[k]),
        .q_valid (w_q_valid[k])
      );
    end else begin : g_tail
      ctrl_stage_reg #(.CW(CW)) u_reg (
        .clk     (clk),
        .reset   (reset),
        .load_en (1'b1),
        .bubble  (1'b0),
        .d_ctrl  (w_q_ctrl[k-1]),
        .d_valid (w_q_valid[k-1]),
        .q_ctrl  (w_q_ctrl[k]),
        .q_valid (w_q_valid[k])
      );
    end
  end

  // Only injected bubbles count: flush always, nop_sel only when it kills a real word.
  assign w_cnt_inc = w_s0_bubble & (flush | id_valid);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bubble_cnt <= '0;
    end else if (w_cnt_inc && (r_bubble_cnt != c_CNT_SAT)) begin
      r_bubble_cnt <= r_bubble_cnt + 16'd1;
    end
  end

  assign stage_ctrl  = w_q_ctrl;
  assign stage_valid = w_q_valid;
  assign wb_rf_e     = w_q_valid[STAGES-1] & w_q_ctrl[STAGES-1][RF_E_BIT];
  assign bubble_cnt  = r_bubble_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_pipe
// Purpose  : Self-checking bench for ctrl_pipe (tables, directed, random)
// Revision : 1.0
// ============================================================================
module tb_ctrl_pipe;

  localparam int STG = 3;
  localparam int CWL = 16;

  logic               clk = 1'b0;
  logic               reset;
  logic [CWL-1:0]     id_ctrl;
  logic               id_valid;
  logic               nop_sel;
  logic               stall;
  logic               flush;
  logic [STG*CWL-1:0] stage_ctrl;
  logic [STG-1:0]     stage_valid;
  logic               wb_rf_e;
  logic [15:0]        bubble_cnt;

  ctrl_pipe #(.CW(CWL), .STAGES(STG), .RF_E_BIT(0)) dut (
    .clk         (clk),
    .reset       (reset),
    .id_ctrl     (id_ctrl),
    .id_valid    (id_valid),
    .nop_sel     (nop_sel),
    .stall       (stall),
    .flush       (flush),
    .stage_ctrl  (stage_ctrl),
    .stage_valid (stage_valid),
    .wb_rf_e     (wb_rf_e),
    .bubble_cnt  (bubble_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: an array of in-flight words indexed by stage.
  logic [CWL-1:0] m_ctrl [STG];
  logic           m_valid[STG];
  int             m_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < STG; k++) begin
      m_ctrl[k]  = '0;
      m_valid[k] = 1'b0;
    end
    m_cnt = 0;
  endtask

  task automatic model_step();
    logic [CWL-1:0] s0c;
    logic           s0v;
    logic           kill;
    s0c = m_ctrl[0];
    s0v = m_valid[0];
    for (int k = STG - 1; k >= 2; k--) begin
      m_ctrl[k]  = m_ctrl[k-1];
      m_valid[k] = m_valid[k-1];
    end
    if (stall && !flush) begin
      m_ctrl[1] = '0; m_valid[1] = 1'b0;
    end else begin
      m_ctrl[1] = s0c; m_valid[1] = s0v;
    end
    kill = 1'b0;
    if (flush) begin
      m_ctrl[0] = '0; m_valid[0] = 1'b0; kill = 1'b1;
    end else if (stall) begin
      m_ctrl[0] = s0c; m_valid[0] = s0v;
    end else if (nop_sel) begin
      m_ctrl[0] = '0; m_valid[0] = 1'b0; kill = id_valid;
    end else begin
      m_ctrl[0]  = id_valid ? id_ctrl : '0;
      m_valid[0] = id_valid;
    end
    if (kill && m_cnt < 65535) m_cnt++;
  endtask

  task automatic model_compare(input string tag);
    logic [STG*CWL-1:0] pc;
    logic [STG-1:0]     pv;
    for (int k = 0; k < STG; k++) begin
      pc[k*CWL +: CWL] = m_ctrl[k];
      pv[k]            = m_valid[k];
    end
    chk({tag, "_ctrl"},  64'(stage_ctrl),  64'(pc));
    chk({tag, "_valid"}, 64'(stage_valid), 64'(pv));
    chk({tag, "_wb"},    64'(wb_rf_e),     64'(m_valid[STG-1] & m_ctrl[STG-1][0]));
    chk({tag, "_cnt"},   64'(bubble_cnt),  64'(m_cnt));
  endtask

  // Drive one cycle of inputs, clock it, advance the model, settle past the edge.
  task automatic apply(input logic [CWL-1:0] c, input logic v, input logic n,
                       input logic s, input logic f);
    id_ctrl = c; id_valid = v; nop_sel = n; stall = s; flush = f;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  typedef struct {
    logic [15:0] c;
    logic        v, n, s, f;
    logic [15:0] e0, e1, e2;
    logic [2:0]  ev;
    logic        ewb;
    logic [15:0] ecnt;
  } vec_t;

  vec_t tbl[15];

  initial begin
    tbl[0]  = '{16'h0041, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0041, 16'h0000, 16'h0000, 3'b001, 1'b0, 16'd0};
    tbl[1]  = '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0041, 16'h0000, 3'b010, 1'b0, 16'd0};
    tbl[2]  = '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0041, 3'b100, 1'b1, 16'd0};
    tbl[3]  = '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 3'b000, 1'b0, 16'd0};
    tbl[4]  = '{16'h1111, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1111, 16'h0000, 16'h0000, 3'b001, 1'b0, 16'd0};
    tbl[5]  = '{16'h2222, 1'b1, 1'b0, 1'b0, 1'b0, 16'h2222, 16'h1111, 16'h0000, 3'b011, 1'b0, 16'd0};
    tbl[6]  = '{16'h3333, 1'b1, 1'b0, 1'b1, 1'b0, 16'h2222, 16'h0000, 16'h1111, 3'b101, 1'b1, 16'd0};
    tbl[7]  = '{16'h3333, 1'b1, 1'b0, 1'b1, 1'b0, 16'h2222, 16'h0000, 16'h0000, 3'b001, 1'b0, 16'd0};
    tbl[8]  = '{16'h3333, 1'b1, 1'b0, 1'b0, 1'b0, 16'h3333, 16'h2222, 16'h0000, 3'b011, 1'b0, 16'd0};
    tbl[9]  = '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h3333, 16'h2222, 3'b110, 1'b0, 16'd0};
    tbl[10] = '{16'h00FF, 1'b1, 1'b0, 1'b0, 1'b0, 16'h00FF, 16'h0000, 16'h3333, 3'b101, 1'b1, 16'd0};
    tbl[11] = '{16'h1234, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h00FF, 16'h0000, 3'b010, 1'b0, 16'd1};
    tbl[12] = '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h00FF, 3'b100, 1'b1, 16'd1};
    tbl[13] = '{16'h5555, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 3'b000, 1'b0, 16'd1};
    tbl[14] = '{16'hABCD, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 3'b000, 1'b0, 16'd1};

    id_ctrl = '0; id_valid = 1'b0; nop_sel = 1'b0; stall = 1'b0; flush = 1'b0;
    reset = 1'b0;
    model_reset();
    #13;
    chk("rst_ctrl",  64'(stage_ctrl),  64'd0);
    chk("rst_valid", 64'(stage_valid), 64'd0);
    chk("rst_wb",    64'(wb_rf_e),     64'd0);
    chk("rst_cnt",   64'(bubble_cnt),  64'd0);
    @(posedge clk);
    #2;
    reset = 1'b1;

    // Directed table: single word latency, stall, flush+stall, nop without valid
    for (int i = 0; i < 15; i++) begin
      apply(tbl[i].c, tbl[i].v, tbl[i].n, tbl[i].s, tbl[i].f);
      chk($sformatf("tbl%0d_s0", i),    64'(stage_ctrl[15:0]),  64'(tbl[i].e0));
      chk($sformatf("tbl%0d_s1", i),    64'(stage_ctrl[31:16]), 64'(tbl[i].e1));
      chk($sformatf("tbl%0d_s2", i),    64'(stage_ctrl[47:32]), 64'(tbl[i].e2));
      chk($sformatf("tbl%0d_valid", i), 64'(stage_valid),       64'(tbl[i].ev));
      chk($sformatf("tbl%0d_wb", i),    64'(wb_rf_e),           64'(tbl[i].ewb));
      chk($sformatf("tbl%0d_cnt", i),   64'(bubble_cnt),        64'(tbl[i].ecnt));
    end

    // nop_sel with valid words: three bubbles drain to WB without a write strobe
    for (int i = 0; i < 3; i++) begin
      apply(16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0);
      chk($sformatf("nop%0d_wb", i),    64'(wb_rf_e),     64'd0);
      chk($sformatf("nop%0d_valid", i), 64'(stage_valid), 64'd0);
    end
    chk("nop_cnt", 64'(bubble_cnt), 64'd4);
    for (int i = 0; i < 3; i++) begin
      apply(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("nopdrain%0d_wb", i), 64'(wb_rf_e), 64'd0);
    end

    // Randomized traffic against the reference
    for (int i = 0; i < 400; i++) begin
      apply(16'($urandom), ($urandom_range(3, 0) != 0), ($urandom_range(5, 0) == 0),
            ($urandom_range(5, 0) == 0), ($urandom_range(7, 0) == 0));
      model_compare($sformatf("rnd%0d", i));
    end

    // Asynchronous reset between edges, then a clean restart
    apply(16'h0041, 1'b1, 1'b0, 1'b0, 1'b0);
    #3;
    reset = 1'b0;
    #1;
    chk("arst_ctrl",  64'(stage_ctrl),  64'd0);
    chk("arst_valid", 64'(stage_valid), 64'd0);
    chk("arst_wb",    64'(wb_rf_e),     64'd0);
    chk("arst_cnt",   64'(bubble_cnt),  64'd0);
    model_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    apply(16'h0C01, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("arst_next_s0",    64'(stage_ctrl[15:0]), 64'h0C01);
    chk("arst_next_valid", 64'(stage_valid),      64'b001);
    model_compare("arst_next");

    // Counter saturation
    do_reset();
    for (int i = 0; i < 65534; i++) apply(16'h0001, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("sat_pre", 64'(bubble_cnt), 64'hFFFE);
    for (int i = 0; i < 3; i++) begin
      apply(16'h0001, 1'b1, 1'b1, 1'b0, 1'b0);
      chk($sformatf("sat%0d", i), 64'(bubble_cnt), 64'hFFFF);
    end
    apply(16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("sat_flush", 64'(bubble_cnt), 64'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ctrl_pipe.md
CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 Parameter CW, default 16: control-word width (ALU_OP, AM, load, mem write, store CC, B, BL, mem size, mem enable, RF_E packed).
REQ-002 Parameter STAGES, default 3: number of post-decode stages (EX, MEM, WB); legal range 2..8.
REQ-003 Parameter RF_E_BIT, default 0: bit index of RF_E within the control word.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 id_ctrl  input  CW  decode-stage control word from the control unit.
REQ-007 id_valid  input  1  id_ctrl holds a real instruction.
REQ-008 nop_sel  input  1  1 = replace the decode word with a bubble (generalised S mux select).
REQ-009 stall  input  1  hold stage 0 and feed a bubble to stage 1.
REQ-010 flush  input  1  kill stage 0 contents.
REQ-011 stage_ctrl  output  STAGES*CW  control word of stage k at bits [k*CW +: CW]; stage 0 = EX.
REQ-012 stage_valid  output  STAGES  valid bit per stage.
REQ-013 wb_rf_e  output  1  register-file write strobe from the last stage.
REQ-014 bubble_cnt  output  16  saturating count of bubbles injected at stage 0.

Function
REQ-015 Bubble = all-zero control word with valid 0.
REQ-016 Stage-0 load priority each cycle: flush > stall > nop_sel > normal.
REQ-017 flush=1: stage 0 loads a bubble; stages 1..STAGES-1 advance normally; stall is ignored that cycle.
REQ-018 stall=1 (no flush): stage 0 holds its value; stage 1 loads a bubble; stages 2..STAGES-1 advance.
REQ-019 nop_sel=1 (no flush, no stall): stage 0 loads a bubble regardless of id_valid.
REQ-020 Normal: stage 0 loads {id_ctrl, id_valid}; when id_valid=0, the stored word is forced to zero.
REQ-021 Stage k (k>=1) loads stage k-1 every cycle, except as modified by REQ-018.
REQ-022 Latency: a word accepted at edge n appears at stage k after edge n+k; wb_rf_e is valid after edge n+STAGES-1.
REQ-023 wb_rf_e = stage_valid[STAGES-1] AND stage_ctrl bit (STAGES-1)*CW+RF_E_BIT; purely combinational from the stage registers.
REQ-024 bubble_cnt increments by 1 at each edge where stage 0 loads a bubble because of flush, or because of nop_sel with id_valid=1; it saturates at 16'hFFFF.
REQ-025 A stall does not increment bubble_cnt; a held stage 0 is not a new bubble.
REQ-026 stall held for m cycles: stage 0 stays unchanged for m edges and stage 1 receives m consecutive bubbles.
REQ-027 All outputs are registered or direct functions of registers; there is no combinational path from the inputs to the outputs.

Reset
REQ-028 While reset=0, asynchronously: every stage_ctrl = 0, stage_valid = 0, bubble_cnt = 0, wb_rf_e = 0.
REQ-029 Reset asserted mid-operation discards all in-flight words; the first edge after deassertion applies REQ-016 normally.

Structure
REQ-030 Package ctrl_pipe_pkg holds default CW, control-word field offsets (ALU_OP[3:0], AM, LOAD, MEM_WRITE, STORE_CC, B, BL, MEM_SIZE, MEM_E, RF_E), the BUBBLE constant, and the saturation limit.
REQ-031 One sub-module, ctrl_stage_reg: a CW+1-bit register with load, hold, and bubble controls; ctrl_pipe instantiates STAGES copies via generate.

Verification
REQ-032 Reset then id_ctrl=16'h0041, id_valid=1 for one cycle -> stage_ctrl stage 0 = 16'h0041 after edge 1, stage 2 = 16'h0041 after edge 3; wb_rf_e=1 after edge 3 only.
REQ-033 Stream words A, B, C; stall=1 on B's cycle for 2 cycles -> stage 0 holds B for 2 extra edges; stage 1 shows 2 bubbles; C reaches stage 0 after the stall ends; bubble_cnt=0.
REQ-034 nop_sel=1 for 3 cycles with id_valid=1 -> 3 bubbles flow to the WB stage; bubble_cnt=3; wb_rf_e stays 0 for them.
REQ-035 flush=1 and stall=1 in the same cycle with stage 0 = 16'h00FF -> stage 0 becomes a bubble, stage 1 receives 16'h00FF, bubble_cnt increments by 1.
REQ-036 Preload bubble_cnt to 16'hFFFE via a long nop_sel run, then 3 more bubbles -> bubble_cnt = 16'hFFFF and holds there.
REQ-037 Assert reset low mid-stream, asynchronously between edges -> all outputs are 0 immediately; after release, the next word enters normally.
